pio_poll_master: RTL and testbench

Avalon-MM master that periodically reads a switch-style PIO slave and mirrors any changed value to an output PIO (for example, LEDs) without CPU involvement. It sits on the EmbeddedCPU interconnect as an additional master, alongside the Nios core. It is the initiator counterpart of the 10-bit input PIO slave. It issues one read per poll tick and one write only when the sampled value changes.

---
 rtl/pio_poll_master.sv | 136 +++++++++++++
 tb/tb_pio_poll_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_master.sv
// Avalon-MM master that polls a source PIO on a fixed tick and mirrors
// changed values to a destination PIO, with a read-data watchdog.
module pio_poll_master #(
  parameter logic [31:0] SRC_ADDR   = 32'h0000_1000,
  parameter logic [31:0] DST_ADDR   = 32'h0000_1010,
  parameter int          DATA_W     = 10,
  parameter int          POLL_DIV   = 50000,
  parameter int          RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] last_value,
  output logic              changed,
  output logic              timeout_err
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ_REQ  = 2'd1;
  localparam logic [1:0] READ_WAIT = 2'd2;
  localparam logic [1:0] WRITE_REQ = 2'd3;

  localparam int CNT_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int WD_W  = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(POLL_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(RD_TIMEOUT);
  localparam logic [31:0]      VAL_MASK = 32'((64'd1 << DATA_W) - 64'd1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WD_W-1:0]  wd;
  logic             tick;
  logic             pending;
  logic             first;
  logic             got;
  logic [31:0]      rd_word;
  logic             diff;

  assign avm_byteenable = 4'hF;
  assign tick = enable && (cnt == '0);
  assign diff = (rd_word[DATA_W-1:0] != last_value) || first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (enable) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

  // A tick raised while busy is held until the FSM gets back to IDLE;
  // dropping enable discards any queued poll.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= 1'b0;
    else       pending <= enable && (tick || (pending && state != IDLE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      last_value    <= '0;
      changed       <= 1'b0;
      timeout_err   <= 1'b0;
      first         <= 1'b1;
      got           <= 1'b0;
      wd            <= '0;
      rd_word       <= '0;
    end else begin
      changed <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && enable) begin
            state       <= READ_REQ;
            avm_read    <= 1'b1;
            avm_address <= SRC_ADDR;
          end
        end
        READ_REQ: begin
          if (!avm_waitrequest) begin
            state       <= READ_WAIT;
            avm_read    <= 1'b0;
            avm_address <= '0;
            wd          <= '0;
            got         <= 1'b0;
          end
        end
        READ_WAIT: begin
          // Data is registered first and compared a cycle later, keeping
          // the bus input off the compare path.
          if (got) begin
            got <= 1'b0;
            if (diff) begin
              state         <= WRITE_REQ;
              avm_write     <= 1'b1;
              avm_address   <= DST_ADDR;
              avm_writedata <= rd_word & VAL_MASK;
            end else begin
              state <= IDLE;
            end
          end else if (avm_readdatavalid) begin
            rd_word <= avm_readdata;
            got     <= 1'b1;
          end else if (wd == WD_LIMIT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          if (!avm_waitrequest) begin
            state       <= IDLE;
            avm_write   <= 1'b0;
            avm_address <= '0;
            last_value  <= rd_word[DATA_W-1:0];
            first       <= 1'b0;
            changed     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_poll_master.sv
// Scoreboard bench: stimulus queues expected bus transactions, a negedge
// monitor pops and checks them as the master presents accepted requests.
module tb_pio_poll_master;
  localparam int PD = 16;
  localparam int RT = 20;
  localparam logic [31:0] SRC = 32'h0000_1000;
  localparam logic [31:0] DST = 32'h0000_1010;

  logic        clk = 0, reset = 1, enable = 0;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_readdatavalid, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic [9:0]  last_value;
  logic        changed, timeout_err;

  pio_poll_master #(.SRC_ADDR(SRC), .DST_ADDR(DST), .DATA_W(10),
                    .POLL_DIV(PD), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest), .last_value(last_value),
    .changed(changed), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; int hold; } txn_t;
  txn_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int stall = 0;
  bit rdv_en = 1;
  logic [9:0] slave_val = '0;
  bit chk_period = 1;
  int rd_acc_cnt = 0, wr_acc_cnt = 0, both_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit wr, input logic [31:0] data, input int hold);
    txn_t t;
    t.wr = wr; t.addr = wr ? DST : SRC; t.data = data; t.hold = hold;
    exp_q.push_back(t);
  endtask

  // Slave model: fixed wait states per request, readdatavalid one cycle
  // after read acceptance, junk in the upper readdata bits.
  initial begin
    int  ws = 0;
    bit  acc_prev = 0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
    forever begin
      @(posedge clk); #1;
      avm_readdatavalid = acc_prev && rdv_en;
      avm_readdata = avm_readdatavalid ? {22'h2AAAAA, slave_val} : 32'hDEAD_BEEF;
      if ((avm_read || avm_write) && !reset) begin
        if (ws < stall) begin avm_waitrequest = 1; ws++; end
        else begin avm_waitrequest = 0; ws = 0; end
      end else begin
        avm_waitrequest = 0; ws = 0;
      end
      acc_prev = avm_read && !avm_waitrequest && !reset;
    end
  end

  // Monitor
  int rd_hold = 0, wr_hold = 0, rd_start = 0, prev_rd = -1;
  logic [31:0] rd_a0, wr_a0, wr_d0;
  bit rd_stab = 1, wr_stab = 1, exp_chg = 0;
  logic [9:0] exp_lv;
  always @(negedge clk) begin
    txn_t t;
    if (reset) begin
      rd_hold = 0; wr_hold = 0; exp_chg = 0; prev_rd = -1;
    end else begin
      if (!chk_period) prev_rd = -1;
      if (avm_read && avm_write) both_cnt++;
      if (exp_chg) begin
        chk("changed_pulse", {31'd0, changed}, 32'd1);
        chk("last_value", {22'd0, last_value}, {22'd0, exp_lv});
        exp_chg = 0;
      end else if (changed) begin
        total++; bad++;
        $display("FAIL changed_unexpected: got 1 expected 0 (t=%0t)", $time);
      end
      if (avm_read) begin
        if (rd_hold == 0) begin
          rd_a0 = avm_address; rd_stab = 1; rd_start = cyc;
          if (prev_rd >= 0) chk("poll_period", cyc - prev_rd, PD);
          prev_rd = cyc;
        end else if (avm_address !== rd_a0) rd_stab = 0;
        rd_hold++;
        if (!avm_waitrequest) begin
          rd_acc_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_read: got read expected none (t=%0t)", $time);
          end else begin
            t = exp_q.pop_front();
            chk("rd_kind", {31'd0, t.wr}, 32'd0);
            chk("rd_addr", avm_address, t.addr);
            chk("rd_hold", rd_hold, t.hold);
            chk("rd_stable", {31'd0, rd_stab}, 32'd1);
          end
          rd_hold = 0;
        end
      end else rd_hold = 0;
      if (avm_write) begin
        if (wr_hold == 0) begin
          wr_a0 = avm_address; wr_d0 = avm_writedata; wr_stab = 1;
          if (stall == 0) chk("rd_to_wr_latency", cyc - rd_start, 3);
        end else if (avm_address !== wr_a0 || avm_writedata !== wr_d0) wr_stab = 0;
        wr_hold++;
        if (!avm_waitrequest) begin
          wr_acc_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got %h expected none (t=%0t)", avm_writedata, $time);
          end else begin
            t = exp_q.pop_front();
            chk("wr_kind", {31'd0, t.wr}, 32'd1);
            chk("wr_addr", avm_address, t.addr);
            chk("wr_data", avm_writedata, t.data);
            chk("wr_hold", wr_hold, t.hold);
            chk("wr_stable", {31'd0, wr_stab}, 32'd1);
            chk("byteenable", {28'd0, avm_byteenable}, 32'hF);
            exp_chg = 1; exp_lv = t.data[9:0];
          end
          wr_hold = 0;
        end
      end else wr_hold = 0;
    end
  end

  task automatic wait_reads(input int k);
    int n = 0;
    while (rd_acc_cnt < k && n < 400) begin @(posedge clk); n++; end
    if (rd_acc_cnt < k) begin
      total++; bad++;
      $display("FAIL wait_reads: got %0d expected %0d", rd_acc_cnt, k);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    chk({tag, "_write"}, {31'd0, avm_write}, 32'd0);
    chk({tag, "_addr"}, avm_address, 32'd0);
    chk({tag, "_wdata"}, avm_writedata, 32'd0);
    chk({tag, "_last_value"}, {22'd0, last_value}, 32'd0);
    chk({tag, "_changed"}, {31'd0, changed}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    int n;
    #3;
    chk_reset_outputs("rst");
    chk("rst_byteenable", {28'd0, avm_byteenable}, 32'hF);
    cycles(3); #2;
    enable = 1; reset = 0;

    // First poll writes 0 even though last_value is already 0
    push(0, 0, 1); push(1, 32'h0, 1); push(0, 0, 1);
    wait_reads(2); cycles(8);

    // Value change, then identical value
    slave_val = 10'h2A5;
    push(0, 0, 1); push(1, 32'h0000_02A5, 1); push(0, 0, 1);
    wait_reads(4); cycles(8);
    #1 chk("lv_2a5", {22'd0, last_value}, 32'h2A5);

    // Three wait states on read and write
    stall = 3; slave_val = 10'h155;
    push(0, 0, 4); push(1, 32'h0000_0155, 4);
    wait_reads(5); cycles(10);
    stall = 0;

    // Read data never returns
    chk_period = 0; rdv_en = 0;
    push(0, 0, 1);
    wait_reads(6);
    cycles(RT - 1); #1;
    chk("tmo_early", {31'd0, timeout_err}, 32'd0);
    n = 0;
    while (!timeout_err && n < 8) begin @(posedge clk); #1; n++; end
    chk("tmo_set", {31'd0, timeout_err}, 32'd1);
    rdv_en = 1;
    push(0, 0, 1);
    wait_reads(7); cycles(4);
    slave_val = 10'h3FF;
    push(0, 0, 1); push(1, 32'h0000_03FF, 1);
    wait_reads(8); cycles(8);
    #1 chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // Enable dropped while waiting for read data
    slave_val = 10'h0AA;
    push(0, 0, 1); push(1, 32'h0000_00AA, 1);
    wait_reads(9); #1 enable = 0;
    cycles(3 * PD + 8); #1;
    chk("en_drop_reads", rd_acc_cnt, 9);
    chk("en_drop_writes", wr_acc_cnt, 5);
    chk("en_drop_lv", {22'd0, last_value}, 32'h0AA);

    // Reset while a write is stalled
    stall = 3; slave_val = 10'h111; enable = 1;
    push(0, 0, 4);
    n = 0;
    while (!avm_write && n < 200) begin @(posedge clk); #1; n++; end
    chk("wr_seen", {31'd0, avm_write}, 32'd1);
    #2 reset = 1;
    #1 chk_reset_outputs("mid_rst");
    cycles(2); #3;
    stall = 0; slave_val = 10'h000;
    push(0, 0, 1); push(1, 32'h0, 1);
    reset = 0;
    wait_reads(11); cycles(8); #1;
    chk("post_rst_writes", wr_acc_cnt, 6);
    chk("post_rst_lv", {22'd0, last_value}, 32'h0);

    chk("queue_empty", exp_q.size(), 0);
    chk("rd_wr_overlap", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
